// File: rtl/tdm_demux_1x4.sv
// 1-to-4 TDM demultiplexer: auto-scan mode decodes sync-framed serial bits into
// four channel outputs; direct mode writes the selected channel straight from din.
module tdm_demux_1x4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       auto,
    input  logic       s1,
    input  logic       s0,
    input  logic       din,
    input  logic       din_valid,
    input  logic       sync,
    output logic [3:0] y,
    output logic       frame_valid,
    output logic [1:0] slot,
    output logic       sync_err
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t     state, state_n;
    logic [1:0] slot_n;
    logic [2:0] shadow, shadow_n;
    logic [3:0] y_n;
    logic       fv_n, se_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            slot        <= 2'd0;
            shadow      <= 3'd0;
            y           <= 4'd0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_n;
            slot        <= slot_n;
            shadow      <= shadow_n;
            y           <= y_n;
            frame_valid <= fv_n;
            sync_err    <= se_n;
        end
    end

    always_comb begin
        state_n  = state;
        slot_n   = slot;
        shadow_n = shadow;
        y_n      = y;
        fv_n     = 1'b0;
        se_n     = 1'b0;
        if (!auto) begin
            // Direct mode parks the framer so re-entering auto always hunts for sync.
            state_n  = IDLE;
            slot_n   = 2'd0;
            shadow_n = 3'd0;
            if (din_valid)
                y_n[{s1, s0}] = din;
        end else if (din_valid) begin
            if (sync) begin
                // Sync always restarts the frame; only mid-frame sync is an error.
                se_n     = (state == RUN) && (slot != 2'd0);
                state_n  = RUN;
                shadow_n = {2'b00, din};
                slot_n   = 2'd1;
            end else if (state == RUN) begin
                case (slot)
                    2'd0: begin
                        se_n    = 1'b1;
                        state_n = IDLE;
                    end
                    2'd1: begin
                        shadow_n[1] = din;
                        slot_n      = 2'd2;
                    end
                    2'd2: begin
                        shadow_n[2] = din;
                        slot_n      = 2'd3;
                    end
                    default: begin
                        y_n    = {din, shadow};
                        fv_n   = 1'b1;
                        slot_n = 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Directed bench for tdm_demux_1x4: auto-mode framing, gaps, sync errors,
// direct mode, mode switching and mid-frame reset.
module tb_tdm_demux_1x4;

    logic       clk = 1'b0;
    logic       rst_n, auto, s1, s0, din, din_valid, sync;
    logic [3:0] y;
    logic       frame_valid, sync_err;
    logic [1:0] slot;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tdm_demux_1x4 dut (
        .clk(clk), .rst_n(rst_n), .auto(auto), .s1(s1), .s0(s0),
        .din(din), .din_valid(din_valid), .sync(sync),
        .y(y), .frame_valid(frame_valid), .slot(slot), .sync_err(sync_err)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one cycle of inputs, then sample #1 after the edge.
    task automatic drive(input logic v, input logic sy, input logic d, input logic [1:0] sel);
        din_valid = v;
        sync      = sy;
        din       = d;
        {s1, s0}  = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic st(input string tag, input logic [3:0] ey, input logic efv,
                      input logic [1:0] esl, input logic ese);
        chk({tag, ".y"}, {4'd0, y}, {4'd0, ey});
        chk({tag, ".fv"}, {7'd0, frame_valid}, {7'd0, efv});
        chk({tag, ".slot"}, {6'd0, slot}, {6'd0, esl});
        chk({tag, ".se"}, {7'd0, sync_err}, {7'd0, ese});
    endtask

    initial begin
        rst_n = 1'b0; auto = 1'b1;
        drive(0, 0, 0, 2'd0);
        drive(0, 0, 0, 2'd0);
        st("reset", 4'b0000, 0, 2'd0, 0);
        rst_n = 1'b1;

        // Basic frame 1,0,1,1
        drive(1, 1, 1, 2'd0); st("f1b0", 4'b0000, 0, 2'd1, 0);
        drive(1, 0, 0, 2'd0); st("f1b1", 4'b0000, 0, 2'd2, 0);
        drive(1, 0, 1, 2'd0); st("f1b2", 4'b0000, 0, 2'd3, 0);
        drive(1, 0, 1, 2'd0); st("f1b3", 4'b1101, 1, 2'd0, 0);
        drive(0, 0, 0, 2'd0); st("f1hold", 4'b1101, 0, 2'd0, 0);

        // Frame 0,1,0,0 -> 0010
        drive(1, 1, 0, 2'd0);
        drive(1, 0, 1, 2'd0);
        drive(1, 0, 0, 2'd0);
        drive(1, 0, 0, 2'd0); st("f2", 4'b0010, 1, 2'd0, 0);

        // Frame 1,0,1,1 with a 3-cycle gap before channel 3
        drive(1, 1, 1, 2'd0);
        drive(1, 0, 0, 2'd0);
        drive(1, 0, 1, 2'd0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 2'd0); st("gap", 4'b0010, 0, 2'd3, 0);
        end
        drive(1, 0, 1, 2'd0); st("gapdone", 4'b1101, 1, 2'd0, 0);

        // Sync on the third bit: error, restart with that bit as channel 0
        drive(1, 1, 0, 2'd0);
        drive(1, 0, 0, 2'd0);
        drive(1, 1, 1, 2'd0); st("midsync", 4'b1101, 0, 2'd1, 1);
        drive(1, 0, 0, 2'd0); st("restart1", 4'b1101, 0, 2'd2, 0);
        drive(1, 0, 1, 2'd0);
        drive(1, 0, 0, 2'd0); st("restart3", 4'b0101, 1, 2'd0, 0);

        // Slot-0 bit without sync: error, back to IDLE, ignore until sync
        drive(1, 0, 1, 2'd0); st("nosync", 4'b0101, 0, 2'd0, 1);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 1, 2'd0); st("hunt", 4'b0101, 0, 2'd0, 0);
        end
        drive(1, 1, 0, 2'd0); st("relock", 4'b0101, 0, 2'd1, 0);
        drive(1, 0, 1, 2'd0);
        drive(1, 0, 1, 2'd0);
        drive(1, 0, 0, 2'd0); st("relockf", 4'b0110, 1, 2'd0, 0);

        // Direct mode
        auto = 1'b0;
        drive(1, 0, 1, 2'd0); st("dir00", 4'b0111, 0, 2'd0, 0);
        drive(1, 0, 1, 2'd1); st("dir01", 4'b0111, 0, 2'd0, 0);
        drive(1, 0, 1, 2'd2); st("dir10", 4'b0111, 0, 2'd0, 0);
        drive(1, 0, 1, 2'd3); st("dir11", 4'b1111, 0, 2'd0, 0);
        drive(1, 0, 0, 2'd1); st("dir01z", 4'b1101, 0, 2'd0, 0);
        drive(1, 1, 0, 2'd3); st("dirsync", 4'b0101, 0, 2'd0, 0);
        drive(0, 0, 1, 2'd0); st("dirgap", 4'b0101, 0, 2'd0, 0);

        // Mode switch drops a partial frame and re-enters IDLE
        auto = 1'b1;
        drive(1, 1, 1, 2'd0);
        drive(1, 0, 1, 2'd0); st("part", 4'b0101, 0, 2'd2, 0);
        auto = 1'b0;
        drive(0, 0, 0, 2'd0); st("drop", 4'b0101, 0, 2'd0, 0);
        auto = 1'b1;
        drive(1, 0, 1, 2'd0); st("idleign", 4'b0101, 0, 2'd0, 0);

        // Reset mid-frame, then a clean frame 1,0,0,1 -> 1001
        drive(1, 1, 1, 2'd0);
        drive(1, 0, 1, 2'd0); st("prerst", 4'b0101, 0, 2'd2, 0);
        rst_n = 1'b0;
        drive(1, 0, 1, 2'd0); st("midrst", 4'b0000, 0, 2'd0, 0);
        rst_n = 1'b1;
        drive(1, 1, 1, 2'd0);
        drive(1, 0, 0, 2'd0);
        drive(1, 0, 0, 2'd0);
        drive(1, 0, 1, 2'd0); st("postrst", 4'b1001, 1, 2'd0, 0);
        drive(0, 0, 0, 2'd0); st("postrst2", 4'b1001, 0, 2'd0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
